// File: rtl/fifo_ex_defs.sv
// Shared definitions for the FIFO example pipeline.
// State encodings and default widths.
package fifo_ex_defs;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    BURST = ST_BURST
  } pacer_state_e;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a level synchronous to clk.
// A level already high out of reset reads as a rise.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/fifo_write_pacer.sv
// Turns each accepted tick into a fixed-length burst of
// incrementing FIFO writes, with back-pressure and overrun count.
module fifo_write_pacer
  import fifo_ex_defs::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                BURST_LEN = 4,
  parameter int                CNT_W     = CNT_W_DEF,
  parameter logic [DATA_W-1:0] DATA_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tick_in,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic [CNT_W-1:0]  overrun_cnt
);

  localparam int BC_W = $clog2(BURST_LEN + 1);

  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(BURST_LEN);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  pacer_state_e    state;
  logic [BC_W-1:0] burst_cnt;
  logic            rise;
  logic            start;

  rise_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tick_in),
    .rise  (rise)
  );

  assign start      = rise & enable;
  assign busy       = (state == BURST);
  assign fifo_wr_en = busy & ~fifo_full;

  // Burst sequencer, write data and saturating overrun counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      fifo_wr_data <= DATA_INIT;
      burst_done   <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      burst_done <= 1'b0;
      if (start && busy && overrun_cnt != CNT_MAX)
        overrun_cnt <= overrun_cnt + CNT_ONE;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= BURST;
            burst_cnt <= BC_LOAD;
          end
        end
        BURST: begin
          if (fifo_wr_en) begin
            fifo_wr_data <= fifo_wr_data + DATA_ONE;
            burst_cnt    <= burst_cnt - BC_ONE;
            if (burst_cnt == BC_ONE) begin
              state      <= IDLE;
              burst_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
